// File: rtl/alien_depth_sorter_pkg.sv
// alien_depth_sorter_pkg: shared record layout, slot width/offsets and object limit
package alien_depth_sorter_pkg;

    localparam int OBJ_LIMIT = 16;
    localparam int SLOT_W    = 35;
    localparam int CNT_W     = 5;

    localparam int ACTIVE_LSB = 0;
    localparam int TYPE_LSB   = 1;
    localparam int FRAME_LSB  = 3;
    localparam int R_LSB      = 5;
    localparam int QUAD_LSB   = 9;
    localparam int X_LSB      = 11;
    localparam int Y_LSB      = 21;
    localparam int DL_LSB     = 31;
    localparam int DR_LSB     = 33;

    typedef struct packed {
        logic [1:0] _deriv_right;
        logic [1:0] _deriv_left;
        logic [9:0] _y_pos;
        logic [9:0] _x_pos;
        logic [1:0] _quadrant;
        logic [3:0] _r;
        logic [1:0] _frame_num;
        logic [1:0] _type;
        logic       _active;
    } alien_data_t;

endpackage

// File: rtl/alien_sort_scan.sv
// alien_sort_scan: level/index scan counters and shadow append pointer for the depth sort
module alien_sort_scan
    import alien_depth_sorter_pkg::*;
#(
    parameter int N_OBJ    = OBJ_LIMIT,
    parameter int R_LEVELS = 16,
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int LW = (R_LEVELS > 1) ? $clog2(R_LEVELS) : 1,
    localparam int CW = $clog2(N_OBJ + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] stored_i,
    input  logic [3:0]    r_i,
    output logic [IW-1:0] idx_o,
    output logic [CW-1:0] wptr_o,
    output logic          hit_o,
    output logic          done_o
);

    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] wptr_q, wptr_d;
    logic          last_idx, last_level;

    // Every (level, index) pair is visited even past the stored count so SORT length is fixed
    always_comb begin
        last_idx   = idx_q == IW'(N_OBJ - 1);
        last_level = level_q == LW'(R_LEVELS - 1);
        hit_o      = en_i && (32'(idx_q) < 32'(stored_i)) && (32'(r_i) == 32'(level_q));
        done_o     = en_i && last_idx && last_level;
        idx_d      = !en_i ? '0 : (last_idx ? '0 : idx_q + 1'b1);
        level_d    = !en_i ? '0 : (last_idx ? (last_level ? '0 : level_q + 1'b1) : level_q);
        wptr_d     = !en_i ? '0 : wptr_q + CW'(hit_o);
    end

    // Counters idle at zero outside SORT so each frame scan starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            idx_q   <= '0;
            wptr_q  <= '0;
        end else begin
            level_q <= level_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
        end
    end

    assign idx_o  = idx_q;
    assign wptr_o = wptr_q;

endmodule

// File: rtl/alien_depth_sorter.sv
// alien_depth_sorter: frame loader, stable counting sort by distance and double-buffered display bank
// Optional build macro SORTER_QUADRANT_FILTER_EN keeps only records in quadrant QUADRANT.
module alien_depth_sorter
    import alien_depth_sorter_pkg::*;
#(
    parameter int N_OBJ    = OBJ_LIMIT,
    parameter int R_LEVELS = 16,
    parameter int QUADRANT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLOT_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic                      frame_sync,
    output logic [N_OBJ*SLOT_W-1:0]   sorted_data,
    output logic [CNT_W-1:0]          sorted_count,
    output logic                      sorted_valid,
    output logic                      late
);

    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int CW = $clog2(N_OBJ + 1);
`ifdef SORTER_QUADRANT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef enum logic [1:0] {LOAD, SORT, HOLD} state_t;

    state_t                  state_q, state_d;
    alien_data_t             rec;
    alien_data_t             bank_q [N_OBJ];
    logic [CW-1:0]           load_idx_q, stored_q;
    logic [N_OBJ*SLOT_W-1:0] shadow_q, sorted_q;
    logic [CNT_W-1:0]        sorted_count_q;
    logic                    sorted_valid_q, late_q;
    logic                    accept, keep, swap, load_done;
    logic [IW-1:0]           scan_idx;
    logic [CW-1:0]           scan_wptr;
    logic                    scan_hit, scan_done;

    alien_sort_scan #(.N_OBJ(N_OBJ), .R_LEVELS(R_LEVELS)) u_scan (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == SORT),
        .stored_i (stored_q),
        .r_i      (bank_q[scan_idx]._r),
        .idx_o    (scan_idx),
        .wptr_o   (scan_wptr),
        .hit_o    (scan_hit),
        .done_o   (scan_done)
    );

    // Handshake decode and next-state: load until last/limit, fixed-length sort, hold until frame_sync
    always_comb begin
        rec       = alien_data_t'(in_data);
        in_ready  = state_q == LOAD;
        accept    = in_valid && in_ready;
        keep      = rec._active && (!FILTER || rec._quadrant == 2'(QUADRANT));
        load_done = load_idx_q == CW'(N_OBJ - 1);
        swap      = frame_sync && state_q == HOLD;
        state_d   = state_q;
        unique case (state_q)
            LOAD:    state_d = (accept && (in_last || load_done)) ? SORT : LOAD;
            SORT:    state_d = scan_done ? HOLD : SORT;
            HOLD:    state_d = frame_sync ? LOAD : HOLD;
            default: state_d = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LOAD;
        else      state_q <= state_d;
    end

    // Input bank only needs valid contents below the stored count, so it carries no reset
    always_ff @(posedge clk) begin
        if (accept && keep) bank_q[stored_q[IW-1:0]] <= rec;
    end

    // Load counters, shadow append, and the frame_sync swap into the display bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_idx_q     <= '0;
            stored_q       <= '0;
            shadow_q       <= '0;
            sorted_q       <= '0;
            sorted_count_q <= '0;
            sorted_valid_q <= 1'b0;
            late_q         <= 1'b0;
        end else begin
            sorted_valid_q <= swap;
            late_q         <= frame_sync && state_q != HOLD;
            if (accept) begin
                load_idx_q <= load_idx_q + 1'b1;
                if (keep) stored_q <= stored_q + 1'b1;
            end
            if (scan_hit) shadow_q[int'(scan_wptr)*SLOT_W +: SLOT_W] <= bank_q[scan_idx];
            if (swap) begin
                sorted_q       <= shadow_q;
                sorted_count_q <= CNT_W'(stored_q);
                load_idx_q     <= '0;
                stored_q       <= '0;
                shadow_q       <= '0;
            end
        end
    end

    assign sorted_data  = sorted_q;
    assign sorted_count = sorted_count_q;
    assign sorted_valid = sorted_valid_q;
    assign late         = late_q;

endmodule

// File: tb/tb_alien_depth_sorter.sv
// tb_alien_depth_sorter: scoreboard bench for the depth sorter (expectations follow SORTER_QUADRANT_FILTER_EN)
module tb_alien_depth_sorter;
    import alien_depth_sorter_pkg::*;

    localparam int N    = 16;
    localparam int W    = N * SLOT_W;
    localparam int QUAD = 2;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             frame_sync = 1'b0;
    logic [SLOT_W-1:0] in_data = '0;
    logic             in_ready;
    logic [W-1:0]     sorted_data;
    logic [4:0]       sorted_count;
    logic             sorted_valid;
    logic             late;

    exp_t         exp_q[$];
    exp_t         mon_e;
    alien_data_t  frame_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_pulses = 0;
    logic [W-1:0] last_data = '0;

    alien_depth_sorter #(.N_OBJ(N), .R_LEVELS(16), .QUADRANT(QUAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .frame_sync   (frame_sync),
        .sorted_data  (sorted_data),
        .sorted_count (sorted_count),
        .sorted_valid (sorted_valid),
        .late         (late)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic alien_data_t mk(input bit act, input int r, input int q, input int x);
        alien_data_t d;
        d           = '0;
        d._active   = act;
        d._r        = 4'(r);
        d._quadrant = 2'(q);
        d._x_pos    = 10'(x);
        d._y_pos    = 10'(x * 3);
        d._type     = 2'(x);
        return d;
    endfunction

    function automatic bit kept(input alien_data_t d);
`ifdef SORTER_QUADRANT_FILTER_EN
        return d._active && d._quadrant == 2'(QUAD);
`else
        return d._active;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alien_data_t d, input bit last);
        int t = 0;
        while (!in_ready && t < 300) begin
            tick();
            t++;
        end
        if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        frame_q.push_back(d);
    endtask

    // Expected bank by insertion sort: each kept record goes after every entry with r <= its r
    task automatic push_expected();
        alien_data_t s[$];
        exp_t        e;
        int          pos;
        foreach (frame_q[i]) begin
            if (kept(frame_q[i])) begin
                pos = s.size();
                while (pos > 0 && s[pos-1]._r > frame_q[i]._r) pos--;
                s.insert(pos, frame_q[i]);
            end
        end
        e.data = '0;
        foreach (s[k]) e.data[k*SLOT_W +: SLOT_W] = s[k];
        e.cnt = 5'(s.size());
        exp_q.push_back(e);
        frame_q.delete();
    endtask

    task automatic swap_frame();
        frame_sync = 1'b1;
        push_expected();
        tick();
        frame_sync = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst && sorted_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) check("sb_unexpected_valid", W'(1), W'(0));
            else begin
                mon_e = exp_q.pop_front();
                check("sb_data", sorted_data, mon_e.data);
                check("sb_count", W'(sorted_count), W'(mon_e.cnt));
                last_data = mon_e.data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int er[5] = '{0, 2, 7, 7, 15};
        int ex[5] = '{4, 2, 1, 3, 5};
        int rr[5] = '{7, 2, 7, 0, 15};
        repeat (2) tick();
        check("rst_count", W'(sorted_count), W'(0));
        check("rst_data", sorted_data, W'(0));
        check("rst_valid", W'(sorted_valid), W'(0));
        check("rst_late", W'(late), W'(0));
        rst = 1'b1;
        tick();
        check("rst_ready", W'(in_ready), W'(1));

        // five records, stable order on equal r
        for (int i = 0; i < 5; i++) send(mk(1, rr[i], QUAD, i + 1), i == 4);
        check("t1_ready_sort", W'(in_ready), W'(0));
        repeat (256) tick();
        p0 = n_pulses;
        swap_frame();
        repeat (2) tick();
        check("t1_pulses", W'(n_pulses - p0), W'(1));
        check("t1_count", W'(sorted_count), W'(5));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t1_slot%0d_r", k), W'(sorted_data[k*SLOT_W+R_LSB +: 4]), W'(er[k]));
            check($sformatf("t1_slot%0d_x", k), W'(sorted_data[k*SLOT_W+X_LSB +: 10]), W'(ex[k]));
        end

        // sixteen records, no in_last: limit, exact SORT length, late during SORT
        for (int i = 0; i < 16; i++) send(mk(1, $urandom_range(0, 15), QUAD, i + 10), 1'b0);
        check("t2_ready_after16", W'(in_ready), W'(0));
        repeat (255) tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t2_late_pulse", W'(late), W'(1));
        check("t2_bank_held", sorted_data, last_data);
        check("t2_no_valid", W'(sorted_valid), W'(0));
        swap_frame();
        check("t2_late_clear", W'(late), W'(0));

        // late during LOAD, then quadrant filter frame
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t3_late_load", W'(late), W'(1));
        send(mk(1, 3, 2, 30), 1'b0);
        send(mk(1, 1, 1, 31), 1'b0);
        send(mk(1, 3, 2, 32), 1'b1);
        repeat (256) tick();
        swap_frame();
`ifdef SORTER_QUADRANT_FILTER_EN
        check("t3_count", W'(sorted_count), W'(2));
`else
        check("t3_count", W'(sorted_count), W'(3));
`endif

        // reset mid-SORT with a non-zero display bank
        send(mk(1, 5, QUAD, 40), 1'b0);
        send(mk(1, 6, QUAD, 41), 1'b1);
        repeat (50) tick();
        #2 rst = 1'b0;
        #1;
        frame_q.delete();
        check("t5_rst_data", sorted_data, W'(0));
        check("t5_rst_count", W'(sorted_count), W'(0));
        check("t5_rst_valid", W'(sorted_valid), W'(0));
        check("t5_rst_late", W'(late), W'(0));
        tick();
        rst = 1'b1;
        tick();
        check("t5_ready_release", W'(in_ready), W'(1));
        send(mk(1, 9, QUAD, 20), 1'b0);
        send(mk(1, 4, QUAD, 21), 1'b1);
        repeat (256) tick();
        swap_frame();
        check("t5_slot0_x", W'(sorted_data[X_LSB +: 10]), W'(21));
        check("t5_slot1_x", W'(sorted_data[SLOT_W+X_LSB +: 10]), W'(20));

        // single inactive record
        send(mk(0, 5, QUAD, 9), 1'b1);
        repeat (256) tick();
        swap_frame();
        check("t4_count", W'(sorted_count), W'(0));
        check("t4_data", sorted_data, W'(0));

        repeat (3) tick();
        check("sb_drain", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
